// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter, MSB first, with hold and done pulse
//
// Purpose:
//   Accepts a WIDTH-bit word on load_i while ready_o is high and shifts it out
//   on sout_o one bit per clock, MSB first. soutb_o is the complement of sout_o.
//   hold_i freezes the shifter while a word is in flight, stretching the
//   current bit. done_o pulses for one cycle after the last bit.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   din_i    parallel word, sampled only on an accepted load
//   load_i   load request, accepted when load_i && ready_o at a rising edge
//   hold_i   pause shifting, honoured only while shifting
//   ready_o  idle, a load will be accepted
//   busy_o   a word is being shifted out
//   sout_o   serial data out, idle level 0
//   soutb_o  complement of sout_o
//   done_o   one-cycle pulse after the last bit of a word

module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             load_i,
  input  logic             hold_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             sout_o,
  output logic             soutb_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          shreg_d = din_i;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!hold_i) begin
          if (cnt_q == '0) begin
            // Clearing the shifter here makes sout_o a plain register bit
            // that is already 0 in DONE and IDLE.
            shreg_d = '0;
            state_d = S_DONE;
          end else begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_SHIFT);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sout_o  = shreg_q[WIDTH-1];
  assign soutb_o = ~shreg_q[WIDTH-1];

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - self-checking bench for piso_tx against a queue-of-cycles reference model

module tb_piso_tx;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] din_i;
  logic         load_i;
  logic         hold_i;
  logic         ready_o;
  logic         busy_o;
  logic         sout_o;
  logic         soutb_o;
  logic         done_o;

  piso_tx #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .din_i   (din_i),
    .load_i  (load_i),
    .hold_i  (hold_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .sout_o  (sout_o),
    .soutb_o (soutb_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the queue holds the expected outputs of the coming
  // cycles. An empty queue means idle and ready.
  typedef struct packed {
    logic sout;
    logic busy;
    logic done;
  } ent_t;

  ent_t exp_q[$];

  logic o_sout, o_done, o_busy, o_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    ent_t e;
    logic eb;
    e  = (exp_q.size() == 0) ? ent_t'(3'b000) : exp_q[0];
    eb = ~e.sout;
    check("ready", ready_o, exp_q.size() == 0);
    check("busy",  busy_o,  e.busy);
    check("done",  done_o,  e.done);
    check("sout",  sout_o,  e.sout);
    check("soutb", soutb_o, eb);
    o_sout  = sout_o;
    o_done  = done_o;
    o_busy  = busy_o;
    o_ready = ready_o;
  endtask

  // One clock: drive inputs, advance the model at the edge, check mid-cycle.
  task automatic step(input logic ld, input logic hd, input logic [W-1:0] d);
    ent_t e;
    load_i = ld;
    hold_i = hd;
    din_i  = d;
    @(posedge clk_i);
    if (exp_q.size() == 0) begin
      if (ld) begin
        for (int i = W - 1; i >= 0; i--) begin
          e.sout = d[i];
          e.busy = 1'b1;
          e.done = 1'b0;
          exp_q.push_back(e);
        end
        e = 3'b001;
        exp_q.push_back(e);
      end
    end else if (!(exp_q[0].busy && hd)) begin
      void'(exp_q.pop_front());
    end
    @(negedge clk_i);
    compare_outputs();
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst_i  = 1'b1;
    load_i = 1'b0;
    hold_i = 1'b0;
    #1;
    check({tag, "_ready"}, ready_o, 1);
    check({tag, "_busy"},  busy_o,  0);
    check({tag, "_done"},  done_o,  0);
    check({tag, "_sout"},  sout_o,  0);
    check({tag, "_soutb"}, soutb_o, 1);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    check({tag, "_done_in_rst"}, done_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check({tag, "_ready_after"}, ready_o, 1);
  endtask

  logic [W-1:0] word, word2;
  int done_at, done_cnt;

  initial begin
    rst_i  = 1'b1;
    load_i = 1'b0;
    hold_i = 1'b0;
    din_i  = '0;
    #1;
    check("rst0_ready", ready_o, 1);
    check("rst0_busy",  busy_o,  0);
    check("rst0_done",  done_o,  0);
    check("rst0_sout",  sout_o,  0);
    check("rst0_soutb", soutb_o, 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b0, 1'b0, '0);

    // Basic word; din_i scrambled after the load must not matter.
    word = '0; done_at = 0;
    for (int c = 1; c <= 10; c++) begin
      step(c == 1, 1'b0, (c == 1) ? 8'hA5 : W'($urandom));
      if (c <= 8) word = {word[W-2:0], o_sout};
      if (o_done) done_at = c;
      if (c == 10) check("a5_ready10", o_ready, 1);
    end
    check("a5_word", word, 8'hA5);
    check("a5_done_at", done_at, 9);

    // Hold during the first 0 bit of 0xF0 (cycle 5) for three cycles.
    done_at = 0;
    for (int c = 1; c <= 13; c++) begin
      step(c == 1, (c >= 6 && c <= 8), (c == 1) ? 8'hF0 : W'($urandom));
      if (c >= 5 && c <= 8) check("hold_bit", o_sout, 0);
      if (o_done) done_at = c;
    end
    check("hold_done_at", done_at, 12);

    // Load attempts while busy are dropped until ready returns.
    word = '0; done_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      step((c == 1) || (c >= 4), 1'b0, (c == 1) ? 8'h3C : 8'hFF);
      if (c <= 8) word = {word[W-2:0], o_sout};
      if (o_done) done_cnt++;
    end
    check("busyload_word", word, 8'h3C);
    check("busyload_dones", done_cnt, 1);
    step(1'b1, 1'b0, 8'hFF);
    check("busyload_accept10", o_busy, 1);
    for (int c = 12; c <= 20; c++) step(1'b0, 1'b0, '0);

    // Back-to-back with load held high.
    word = '0; word2 = '0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      step(c <= 11, 1'b0, (c <= 10) ? 8'h81 : 8'h7E);
      if (c <= 8) word = {word[W-2:0], o_sout};
      if (c >= 11 && c <= 18) word2 = {word2[W-2:0], o_sout};
      if (o_done && done_at == 0) done_at = c;
      if (c == 10) check("b2b_gap_sout", o_sout, 0);
      if (c == 11) check("b2b_start11", o_busy, 1);
    end
    check("b2b_word1", word, 8'h81);
    check("b2b_word2", word2, 8'h7E);
    check("b2b_done_at", done_at, 9);

    // Reset during bit 5 of 0xFF, then a normal word.
    for (int c = 1; c <= 5; c++) step(c == 1, 1'b0, 8'hFF);
    do_reset("rstmid");
    word = '0; done_at = 0;
    for (int c = 1; c <= 10; c++) begin
      step(c == 1, 1'b0, 8'h01);
      if (c <= 8) word = {word[W-2:0], o_sout};
      if (o_done) done_at = c;
    end
    check("post_rst_word", word, 8'h01);
    check("post_rst_done_at", done_at, 9);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) do_reset("rnd_rst");
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
